// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the TX FIFO side and the UART transmitter.
//   tx_start  request to send din (honoured only while tx_ready is high)
//   din       byte to send
//   parity    00 none, 01 odd, 10 even, 11 none
//   tx_ready  transmitter idle and able to accept a byte
//   tx_busy   inverse of tx_ready
//   tx_done   one-cycle pulse at the end of the stop bit
// master: byte source. slave: transmitter.
interface uart_tx_serializer_if;
    logic       tx_start;
    logic [7:0] din;
    logic [1:0] parity;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output din,
        output parity,
        input  tx_ready,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  din,
        input  parity,
        output tx_ready,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional odd/even parity bit, one stop bit.
// Bit timing comes from the shared oversampling baud-tick strobe.
//   clk       system clock
//   a_resetn  asynchronous active-low reset
//   b_tick    baud-tick strobe, one clk wide, TICKS_PER_BIT per serial bit
//   tx        registered serial output, idles high
//   bus       byte handshake (slave side): tx_start/din/parity in, tx_ready/tx_busy/tx_done out
module uart_tx_serializer #(
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       a_resetn,
    input  logic                       b_tick,
    output logic                       tx,
    uart_tx_serializer_if.slave        bus
);

    localparam logic [3:0] LastTick = 4'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e     state_q;
    logic [3:0] tick_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       par_en_q;
    logic       par_bit_q;
    logic       bit_end;

    // Last tick of the current serial bit; only meaningful outside idle.
    assign bit_end = b_tick && (tick_q == LastTick);

    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q      <= StIdle;
            tick_q       <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            tx           <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.tx_busy  <= 1'b0;
            bus.tx_done  <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;

            // Ticks are ignored in idle, so the start bit phase begins at the first tick
            // after acceptance.
            if (state_q != StIdle && b_tick) begin
                tick_q <= bit_end ? 4'd0 : tick_q + 4'd1;
            end

            case (state_q)
                StIdle: begin
                    tx <= 1'b1;
                    if (bus.tx_start) begin
                        shift_q      <= bus.din;
                        par_en_q     <= (bus.parity == 2'b01) || (bus.parity == 2'b10);
                        par_bit_q    <= (bus.parity == 2'b01) ? ~^bus.din : ^bus.din;
                        tick_q       <= 4'd0;
                        bit_idx_q    <= 3'd0;
                        tx           <= 1'b0;
                        bus.tx_ready <= 1'b0;
                        bus.tx_busy  <= 1'b1;
                        state_q      <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        tx      <= shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            if (par_en_q) begin
                                tx      <= par_bit_q;
                                state_q <= StParity;
                            end else begin
                                tx      <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            // Next data bit is the one about to shift into position 0.
                            tx <= shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        bus.tx_done  <= 1'b1;
                        bus.tx_ready <= 1'b1;
                        bus.tx_busy  <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    tx           <= 1'b1;
                    bus.tx_ready <= 1'b1;
                    bus.tx_busy  <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic clk;
    logic a_resetn;
    logic b_tick;
    logic tx;

    uart_tx_serializer_if bus ();

    uart_tx_serializer #(
        .TICKS_PER_BIT (16)
    ) dut (
        .clk      (clk),
        .a_resetn (a_resetn),
        .b_tick   (b_tick),
        .tx       (tx),
        .bus      (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
    } exp_t;

    exp_t sb_q[$];
    int   tests;
    int   fails;
    int   n_exp;
    int   n_frames;
    int   done_cnt;
    bit   busy_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick every 4 clk, changed just after the rising edge.
    initial begin
        int ph;
        ph     = 0;
        b_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph     = (ph + 1) % 4;
            b_tick = (ph == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_par(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    // Odd: data plus parity has an odd number of ones. Even: an even number.
    function automatic logic exp_par(input logic [7:0] d, input logic [1:0] m);
        int ones;
        ones = $countones(d);
        if (m == 2'b01) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    // Cycle-level observers.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_done === 1'b1) done_cnt++;
            if (a_resetn === 1'b1 && bus.tx_busy !== ~bus.tx_ready) busy_bad = 1'b1;
        end
    end

    // Line monitor: decodes each frame mid-bit and checks it against the scoreboard.
    initial begin
        logic [10:0] bits;
        int          ticks;
        int          nbits;
        bit          aborted;
        bit          early;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (a_resetn === 1'b1 && tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 32'(sb_q.size()), 32'd1);
                    continue;
                end
                e       = sb_q[0];
                nbits   = has_par(e.mode) ? 11 : 10;
                ticks   = 0;
                aborted = 1'b0;
                early   = 1'b0;
                bits    = '1;
                while (1) begin
                    if (a_resetn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (bus.tx_done === 1'b1) early = 1'b1;
                    if (b_tick === 1'b1) begin
                        ticks++;
                        if (ticks % 16 == 8) bits[ticks / 16] = tx;
                        if (ticks == 16 * nbits) break;
                    end
                    @(negedge clk);
                end
                if (aborted) begin
                    e = sb_q.pop_front();
                    continue;
                end
                @(negedge clk);
                chk("done_pulse", 32'(bus.tx_done), 32'd1);
                chk("ready_after_stop", 32'(bus.tx_ready), 32'd1);
                chk("start_bit", 32'(bits[0]), 32'd0);
                chk("data_byte", 32'(bits[8:1]), 32'(e.data));
                if (has_par(e.mode)) chk("parity_bit", 32'(bits[9]), 32'(exp_par(e.data, e.mode)));
                chk("stop_bit", 32'(bits[nbits-1]), 32'd1);
                chk("early_done", 32'(early), 32'd0);
                n_frames++;
                e = sb_q.pop_front();
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.tx_ready !== 1'b1 && n < 5000);
        chk("send_ready", 32'(bus.tx_ready), 32'd1);
        bus.din      = d;
        bus.parity   = m;
        bus.tx_start = 1'b1;
        sb_q.push_back('{data: d, mode: m});
        n_exp++;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.tx_ready !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_complete", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] pat [4];
        bit         stable;
        int         n;
        int         done_before;

        tests    = 0;
        fails    = 0;
        n_exp    = 0;
        n_frames = 0;
        done_cnt = 0;
        busy_bad = 1'b0;
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h55;
        pat[3] = 8'h80;

        bus.tx_start = 1'b0;
        bus.din      = 8'h00;
        bus.parity   = 2'b00;
        a_resetn     = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("rst_done", 32'(bus.tx_done), 32'd0);
        a_resetn = 1'b1;
        stable = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 ||
                bus.tx_done !== 1'b0) stable = 1'b0;
        end
        chk("idle_stable", 32'(stable), 32'd1);

        // Basic frames and parity modes.
        send(8'hA5, 2'b00); wait_idle();
        send(8'h03, 2'b01); wait_idle();
        send(8'h03, 2'b10); wait_idle();
        send(8'h03, 2'b11); wait_idle();

        // Every parity mode against a set of edge bytes.
        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < 4; b++) begin
                send(pat[b], 2'(m));
                wait_idle();
            end
        end

        // A second request and a parity change mid-frame must not disturb the frame.
        send(8'hA5, 2'b00);
        repeat (200) @(posedge clk);
        #1;
        bus.din      = 8'h3C;
        bus.parity   = 2'b01;
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        wait_idle();
        repeat (300) @(negedge clk);
        chk("ignored_request", 32'(n_frames), 32'(n_exp));
        chk("line_idle", 32'(tx), 32'd1);

        // Back-to-back: tx_start held through the tx_done cycle.
        @(posedge clk);
        #1;
        bus.din      = 8'h55;
        bus.parity   = 2'b01;
        bus.tx_start = 1'b1;
        sb_q.push_back('{data: 8'h55, mode: 2'b01});
        n_exp++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tx_done !== 1'b1 && n < 2000);
        chk("b2b_done_seen", 32'(bus.tx_done), 32'd1);
        chk("b2b_stop_level", 32'(tx), 32'd1);
        bus.din = 8'h80;
        sb_q.push_back('{data: 8'h80, mode: 2'b01});
        n_exp++;
        @(negedge clk);
        chk("b2b_gap", 32'(tx), 32'd0);
        chk("b2b_busy", 32'(bus.tx_ready), 32'd0);
        bus.tx_start = 1'b0;
        wait_idle();

        // Reset during data bit 4, then a clean frame.
        send(8'h96, 2'b10);
        n = 0;
        while (n < 88) begin
            @(negedge clk);
            if (b_tick === 1'b1) n++;
        end
        done_before = done_cnt;
        #2;
        a_resetn = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("mid_rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("mid_rst_done", 32'(bus.tx_done), 32'd0);
        n_exp--;
        repeat (5) @(negedge clk);
        #2;
        a_resetn = 1'b1;
        repeat (50) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt), 32'(done_before));
        chk("abort_dropped", 32'(sb_q.size()), 32'd0);
        send(8'h3C, 2'b10);
        wait_idle();

        chk("frame_count", 32'(n_frames), 32'(n_exp));
        chk("done_count", 32'(done_cnt), 32'(n_exp));
        chk("busy_not_ready", 32'(busy_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter paired with the team's oversampling UART receiver. It accepts one byte per handshake from the AXI-Lite/TX-FIFO side and serializes it onto `tx`: start bit, 8 data bits LSB first, an optional odd or even parity bit, then one stop bit. Bit timing uses the same 16x `b_tick` baud-tick generator as the receiver, so frames round-trip through the receiver with matching `parity` settings.

## Interface
Parameters:
- TICKS_PER_BIT, 16, number of `b_tick` pulses per serial bit; must match the receiver oversampling.

Ports:
- clk  in  1  system clock.
- a_resetn  in  1  reset: asynchronous, active-low.
- b_tick  in  1  baud-tick strobe, one `clk` cycle wide, at 16x the baud rate.
- parity  in  2  parity mode: 00 none, 01 odd, 10 even, 11 treated as none. Sampled at byte acceptance.
- tx_start  in  1  request to send `din`. Accepted only when `tx_ready`=1.
- din  in  8  byte to send. Sampled in the cycle `tx_start` is accepted.
- tx_ready  out  1  registered. High only in IDLE.
- tx  out  1  registered serial line output. Idle level is 1.
- tx_busy  out  1  registered. Equals `!tx_ready`.
- tx_done  out  1  registered one-`clk` pulse at the end of the stop bit.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. State is IDLE; the tick counter, bit index and shift register are 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1. `tx_done` is low, except in the single cycle after the STOP exit.
  - On `tx_start`=1, latch `din` into the shift register and latch the `parity` mode.
  - Compute the parity bit: even = ^din; odd = ~^din. With odd parity, data plus parity bit contain an odd number of ones.
  - Clear the counters and go to START.
- Tick counter: 4 bits, counts only on `b_tick`. A bit ends on the `b_tick` where count = TICKS_PER_BIT-1; the counter then resets to 0.
- START: `tx`=0 for TICKS_PER_BIT ticks, then go to DATA.
- DATA:
  - `tx` = shift_reg[0].
  - At the end of each bit: shift right, increment the bit index.
  - After bit index 7, go to PARITY if the latched mode is 01 or 10, else go to STOP.
- PARITY: `tx` = latched parity bit for one bit time, then go to STOP.
- STOP: `tx`=1 for one bit time. At the end of the bit: pulse `tx_done` for one cycle, set `tx_ready`=1, go to IDLE.
- `tx_start` is ignored while `tx_ready`=0. No queueing: the upstream FIFO holds data until `tx_ready`.
- Changes to `din` or `parity` during a frame do not affect that frame.
- `b_tick` is ignored in IDLE. The bit phase starts at counter 0 from the first `b_tick` after acceptance.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous). The partial frame is abandoned; no `tx_done`.

## Timing
- Acceptance: in the cycle where `tx_start`=1 and `tx_ready`=1, the block samples the inputs. On the next `clk` edge, `tx_ready`=0, `tx_busy`=1 and `tx`=0.
- Start bit duration: from acceptance edge to the edge after the 16th `b_tick`.
- Frame length in `b_tick`s: 160 with no parity (10 bits); 176 with parity (11 bits). The start bit can be up to one tick period longer, set by `b_tick` phase.
- `tx` changes only on the `clk` edge following the terminating `b_tick` of the previous bit.
- `tx_done`, `tx_ready`=1 and STOP→IDLE all occur on the same edge.
- Back-to-back frames: `tx_start` held high in the `tx_done` cycle is accepted. `tx` then goes 1→0 on the next edge, giving a minimum idle of one `clk` cycle between the stop and the next start bit.
- Simultaneous `tx_start` and `b_tick` in IDLE: the tick is not counted.

## Test plan
- Reset: hold `a_resetn`=0 → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. Release with no `tx_start` → outputs unchanged for 1000 cycles.
- No parity, `din`=8'hA5, `b_tick` every 4 clk → `tx` bits 0,1,0,1,0,0,1,0,1,1, each 16 ticks. One `tx_done` pulse, then `tx_ready`=1.
- Odd parity, `din`=8'h03 → parity bit 1. Even parity, `din`=8'h03 → parity bit 0. `parity`=11 → no parity bit (10-bit frame).
- Loopback into the receiver with each parity mode, bytes 00, FF, 55, 80 → receiver `dout` equals sent byte and `rx_done` pulses each frame.
- `tx_start` pulsed mid-frame with a different `din`, and `parity` changed mid-frame → current frame unchanged, second request ignored. `tx_start` held continuously → consecutive frames separated by exactly one idle `clk`.
- `a_resetn` asserted during DATA bit 4 → `tx`=1 immediately, no `tx_done`. After release, a new `tx_start` sends a complete correct frame.
